// File: rtl/pkt_pkg.sv
// Shared types and helpers for the packet word-to-byte serializer.
// Holds the FSM state type, count width and bytes-per-word decode.
package pkt_pkg;

    localparam int PKT_COUNT_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN,
        EOP
    } packet_state_t;

    // A running count ending on a 4-byte boundary means a full word.
    function automatic logic [2:0] bytes_per_word(
        input logic [PKT_COUNT_W-1:0] bc
    );
        return (bc[1:0] == 2'b00) ? 3'd4 : {1'b0, bc[1:0]};
    endfunction

endpackage

// File: rtl/pkt_words_to_bytes_if.sv
// Word-side and byte-side handshake bundle for pkt_words_to_bytes.
// The slave view belongs to the serializer, the master view to its peers.
interface pkt_words_to_bytes_if;
    import pkt_pkg::*;

    logic [31:0]            data;
    logic [PKT_COUNT_W-1:0] bytecount;
    logic                   valid;
    logic                   ready;
    logic                   eop;
    logic [7:0]             txdata;
    logic                   txvalid;
    logic                   txready;
    logic                   txeop;
    logic                   err;

    modport master (
        output data, bytecount, valid, eop, txready,
        input  ready, txdata, txvalid, txeop, err
    );

    modport slave (
        input  data, bytecount, valid, eop, txready,
        output ready, txdata, txvalid, txeop, err
    );

endinterface

// File: rtl/pkt_word_skid.sv
// One-entry holding register for a word and its running byte count.
// Load wins over unload; both are never requested together by the top.
module pkt_word_skid
    import pkt_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   unload,
    input  logic [31:0]            din,
    input  logic [PKT_COUNT_W-1:0] bc_in,
    output logic                   full,
    output logic [31:0]            dout,
    output logic [PKT_COUNT_W-1:0] bc_out
);

    logic                   full_q, full_d;
    logic [31:0]            data_q, data_d;
    logic [PKT_COUNT_W-1:0] bc_q, bc_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        bc_d   = bc_q;
        if (load) begin
            full_d = 1'b1;
            data_d = din;
            bc_d   = bc_in;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            bc_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            bc_q   <= bc_d;
        end
    end

    assign full   = full_q;
    assign dout   = data_q;
    assign bc_out = bc_q;

endmodule

// File: rtl/pkt_words_to_bytes.sv
// Serializes byte-count-tagged 32-bit packet words into a byte stream,
// little-endian first, with a trailing one-cycle end-of-packet strobe.
module pkt_words_to_bytes
    import pkt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    pkt_words_to_bytes_if.slave  bus
);

    packet_state_t          state_q, state_d;
    logic [31:0]            cur_data_q, cur_data_d;
    logic [2:0]             cur_cnt_q, cur_cnt_d;
    logic                   eop_seen_q, eop_seen_d;
    logic [PKT_COUNT_W-1:0] exp_q, exp_d;
    logic                   err_q, err_d;

    logic                   pend_full;
    logic [31:0]            pend_data;
    logic [PKT_COUNT_W-1:0] pend_bc;
    logic                   pend_load, pend_unload;
    logic                   xfer, last, cur_empty_nx;
    logic                   acc, drained, legal;
    logic [PKT_COUNT_W-1:0] diff;

    assign bus.ready    = rst_n && !pend_full && !eop_seen_q;
    assign xfer         = (cur_cnt_q != 3'd0) && bus.txready;
    assign last         = xfer && (cur_cnt_q == 3'd1);
    assign cur_empty_nx = (cur_cnt_q == 3'd0) || last;
    // A word seen together with eop is dropped, not accepted.
    assign acc          = bus.valid && bus.ready && !bus.eop;
    assign drained      = cur_empty_nx && !pend_full && !acc;
    assign pend_load    = acc && !cur_empty_nx;
    assign pend_unload  = last && pend_full;

    assign diff  = bus.bytecount - exp_q;
    assign legal = (exp_q[1:0] == 2'b00) && (bus.bytecount > exp_q) &&
                   (diff <= 12'd4);

    pkt_word_skid u_pend (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pend_load),
        .unload (pend_unload),
        .din    (bus.data),
        .bc_in  (bus.bytecount),
        .full   (pend_full),
        .dout   (pend_data),
        .bc_out (pend_bc)
    );

    always_comb begin
        cur_data_d = cur_data_q;
        cur_cnt_d  = cur_cnt_q;
        if (xfer) begin
            cur_data_d = {8'h00, cur_data_q[31:8]};
            cur_cnt_d  = cur_cnt_q - 3'd1;
        end
        if (pend_unload) begin
            cur_data_d = pend_data;
            cur_cnt_d  = bytes_per_word(pend_bc);
        end else if (acc && cur_empty_nx) begin
            cur_data_d = bus.data;
            cur_cnt_d  = bytes_per_word(bus.bytecount);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.eop)  state_d = EOP;
                else if (acc) state_d = SEND;
            end
            SEND: begin
                if (bus.eop) state_d = drained ? EOP : DRAIN;
            end
            DRAIN: begin
                if (drained) state_d = EOP;
            end
            EOP: begin
                if (acc)          state_d = SEND;
                else if (bus.eop) state_d = EOP;
                else              state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing on entry to EOP lets the next packet start during txeop.
    always_comb begin
        eop_seen_d = eop_seen_q;
        exp_d      = exp_q;
        if (state_d == EOP) begin
            eop_seen_d = 1'b0;
            exp_d      = '0;
        end else begin
            if (bus.eop) eop_seen_d = 1'b1;
            if (acc)     exp_d      = bus.bytecount;
        end
        err_d = (bus.valid && bus.eop) || (acc && !legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_data_q <= '0;
            cur_cnt_q  <= '0;
            eop_seen_q <= 1'b0;
            exp_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_data_q <= cur_data_d;
            cur_cnt_q  <= cur_cnt_d;
            eop_seen_q <= eop_seen_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        bus.txeop   = (state_q == EOP);
        bus.txvalid = (cur_cnt_q != 3'd0);
        bus.txdata  = cur_data_q[7:0];
        bus.err     = err_q;
    end

endmodule

// File: tb/tb_pkt_words_to_bytes.sv
// Scoreboard bench for pkt_words_to_bytes: directed packets in,
// expected bytes and eop markers queued, monitor pops on each output.
module tb_pkt_words_to_bytes;

    typedef struct {
        bit         is_eop;
        logic [7:0] b;
        bit         contig;
    } item_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   err_exp;
    int   err_seen;
    int   cyc;
    int   last_cyc;
    int   txr_mode;
    item_t sbq[$];

    pkt_words_to_bytes_if bus();

    pkt_words_to_bytes dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d",
                     name, got, expv, cyc);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [11:0] bc,
                               input bit c0, input bit c);
        int n;
        logic [31:0] w;
        item_t it;
        n = (bc[1:0] == 2'b00) ? 4 : int'(bc[1:0]);
        w = d;
        for (int i = 0; i < n; i++) begin
            it.is_eop = 1'b0;
            it.b      = w[7:0];
            it.contig = (i == 0) ? c0 : c;
            sbq.push_back(it);
            w = w >> 8;
        end
    endtask

    task automatic expect_eop(input bit c);
        item_t it;
        it.is_eop = 1'b1;
        it.b      = 8'h00;
        it.contig = c;
        sbq.push_back(it);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [11:0] bc);
        int t;
        t = 0;
        bus.data      = d;
        bus.bytecount = bc;
        bus.valid     = 1'b1;
        @(negedge clk);
        while (!bus.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready_timeout", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic send_eop();
        bus.eop = 1'b1;
        @(posedge clk);
        #1;
        bus.eop = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", sbq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (txr_mode)
                0: bus.txready = 1'b1;
                1: begin
                    bus.txready = (k % 4 == 0) || (k % 4 == 3);
                    k++;
                end
                default: bus.txready = 1'b0;
            endcase
        end
    end

    initial begin
        bit         stalled;
        logic [7:0] held;
        item_t      it;
        stalled = 1'b0;
        held    = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_txvalid", {31'd0, bus.txvalid}, 32'd1);
                    chk("stall_txdata", {24'd0, bus.txdata}, {24'd0, held});
                end
                stalled = bus.txvalid && !bus.txready;
                held    = bus.txdata;
                if (bus.err) err_seen++;
                chk("txeop_excl", {31'd0, bus.txvalid & bus.txeop}, 32'd0);
                if ((bus.txvalid && bus.txready) || bus.txeop) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output txdata %0h txeop %0b expected nothing",
                                 bus.txdata, bus.txeop);
                    end else begin
                        it = sbq.pop_front();
                        chk("out_kind", {31'd0, bus.txeop}, {31'd0, it.is_eop});
                        if (!it.is_eop)
                            chk("out_byte", {24'd0, bus.txdata}, {24'd0, it.b});
                        if (it.contig)
                            chk("out_gap", cyc, last_cyc + 1);
                    end
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        err_exp       = 0;
        err_seen      = 0;
        cyc           = 0;
        last_cyc      = 0;
        txr_mode      = 0;
        rst_n         = 1'b0;
        bus.data      = '0;
        bus.bytecount = '0;
        bus.valid     = 1'b0;
        bus.eop       = 1'b0;
        bus.txready   = 1'b1;

        #1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txvalid", {31'd0, bus.txvalid}, 32'd0);
        chk("rst_txeop", {31'd0, bus.txeop}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_txdata", {24'd0, bus.txdata}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;

        // Two full words, gapless bytes then txeop.
        expect_word(32'h44332211, 12'd4, 1'b0, 1'b1);
        expect_word(32'h88776655, 12'd8, 1'b1, 1'b1);
        expect_eop(1'b1);
        send_word(32'h44332211, 12'd4);
        send_word(32'h88776655, 12'd8);
        send_eop();
        wait_drain();

        // Partial word: the unused top byte must not appear.
        expect_word(32'h00CCBBAA, 12'd3, 1'b0, 1'b1);
        expect_eop(1'b1);
        send_word(32'h00CCBBAA, 12'd3);
        send_eop();
        wait_drain();

        // Back-pressure: stalled bytes hold, pending slot blocks ready.
        txr_mode = 1;
        expect_word(32'h44332211, 12'd4, 1'b0, 1'b0);
        expect_word(32'h88776655, 12'd8, 1'b0, 1'b0);
        expect_eop(1'b0);
        send_word(32'h44332211, 12'd4);
        send_word(32'h88776655, 12'd8);
        chk("ready_pend_full", {31'd0, bus.ready}, 32'd0);
        send_eop();
        wait_drain();
        txr_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Empty packet.
        expect_eop(1'b0);
        send_eop();
        chk("empty_txeop", {31'd0, bus.txeop}, 32'd1);
        chk("empty_txvalid", {31'd0, bus.txvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("empty_txeop_1cyc", {31'd0, bus.txeop}, 32'd0);
        wait_drain();

        // Misaligned running count.
        expect_word(32'hDDCCBBAA, 12'd2, 1'b0, 1'b1);
        expect_word(32'h44332211, 12'd6, 1'b1, 1'b1);
        expect_eop(1'b1);
        send_word(32'hDDCCBBAA, 12'd2);
        chk("legal_no_err", {31'd0, bus.err}, 32'd0);
        send_word(32'h44332211, 12'd6);
        err_exp++;
        chk("misalign_err", {31'd0, bus.err}, 32'd1);
        @(posedge clk);
        #1;
        chk("misalign_err_1cyc", {31'd0, bus.err}, 32'd0);
        send_eop();
        wait_drain();

        // Word together with eop: dropped, error, eop still honoured.
        expect_eop(1'b0);
        bus.data      = 32'hCAFEF00D;
        bus.bytecount = 12'd4;
        bus.valid     = 1'b1;
        bus.eop       = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.eop   = 1'b0;
        err_exp++;
        chk("veop_err", {31'd0, bus.err}, 32'd1);
        chk("veop_txeop", {31'd0, bus.txeop}, 32'd1);
        chk("veop_txvalid", {31'd0, bus.txvalid}, 32'd0);
        wait_drain();

        // Reset mid-word discards everything silently.
        txr_mode = 2;
        send_word(32'h44332211, 12'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_txvalid", {31'd0, bus.txvalid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txvalid", {31'd0, bus.txvalid}, 32'd0);
        chk("mid_rst_txeop", {31'd0, bus.txeop}, 32'd0);
        chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("mid_rst_txdata", {24'd0, bus.txdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        txr_mode = 0;
        #1;
        chk("mid_rst_ready_after", {31'd0, bus.ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;

        chk("sb_empty", sbq.size(), 0);
        chk("err_count", err_seen, err_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
